// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the PC alignment helper.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  // Instructions are word aligned; low address bits are always forced to zero.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter, pending-kill flag and latched redirect target.
// The fetch FSM drives one-cycle strobes; this block decides the next pc.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            inc_en,
  input  logic            redir_load,
  input  logic            kill_set,
  input  logic            kill_take,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            kill_pending
);

  logic [PC_W-1:0] kill_tgt;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] tgt_next;
  logic            kill_next;

  // A direct redirect overrides a pending kill target; a newer kill target
  // simply overwrites the older one so only one beat is ever discarded.
  always_comb begin
    pc_next   = pc;
    tgt_next  = kill_tgt;
    kill_next = kill_pending;
    if (redir_load) begin
      pc_next   = align_pc(redirect_pc);
      kill_next = 1'b0;
    end else if (kill_take) begin
      pc_next   = kill_tgt;
      kill_next = 1'b0;
    end else if (inc_en) begin
      pc_next = pc + PC_W'(4);
    end
    if (kill_set) begin
      tgt_next  = align_pc(redirect_pc);
      kill_next = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pc           <= align_pc(RESET_PC);
      kill_tgt     <= '0;
      kill_pending <= 1'b0;
    end else begin
      pc           <= pc_next;
      kill_tgt     <= tgt_next;
      kill_pending <= kill_next;
    end
  end

endmodule

// File: rtl/ifu_fetch_master.sv
// AXI4-Lite read master that fetches one instruction at a time and hands it
// to the decode stage over a valid/ready pair, honouring EXU redirects.
//
// Handshakes: a transfer occurs on any rising edge where valid && ready.
// valid, once raised, stays high with its payload stable until the transfer;
// ready may change freely. inst_valid is the exception: a redirect withdraws it.
module ifu_fetch_master
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              aclk,
  input  logic              aresetn,
  output logic              arvalid,
  input  logic              arready,
  output logic [PC_W-1:0]   araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [INST_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_err,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [1:0]        dbg_state
);

  ifu_state_e      state;
  logic [PC_W-1:0] pc;
  logic            kill_pending;
  logic            inc_en;
  logic            redir_load;
  logic            kill_set;
  logic            kill_take;
  logic            beat;

  assign beat      = rvalid && rready;
  assign araddr    = pc;
  assign dbg_state = state;

  // pc is never loaded while in ADDR, which keeps araddr stable on the bus.
  always_comb begin
    inc_en     = 1'b0;
    redir_load = 1'b0;
    kill_set   = 1'b0;
    kill_take  = 1'b0;
    case (state)
      IDLE: redir_load = redirect_valid;
      ADDR: kill_set = redirect_valid;
      DATA: begin
        if (beat) begin
          if (redirect_valid) redir_load = 1'b1;
          else if (kill_pending) kill_take = 1'b1;
        end else begin
          kill_set = redirect_valid;
        end
      end
      HOLD: begin
        redir_load = redirect_valid;
        inc_en     = inst_ready && !redirect_valid;
      end
      default: ;
    endcase
  end

  ifu_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .inc_en      (inc_en),
    .redir_load  (redir_load),
    .kill_set    (kill_set),
    .kill_take   (kill_take),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .kill_pending(kill_pending)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= ADDR;
          arvalid <= 1'b1;
        end
        ADDR: begin
          if (arready) begin
            state   <= DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        DATA: begin
          // A beat that raced with, or follows, a redirect is dropped here.
          if (rvalid) begin
            rready <= 1'b0;
            if (redirect_valid || kill_pending) begin
              state   <= ADDR;
              arvalid <= 1'b1;
            end else begin
              state      <= HOLD;
              inst_valid <= 1'b1;
              inst       <= rdata;
              inst_pc    <= pc;
              inst_err   <= (rresp != 2'b00);
            end
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            state      <= ADDR;
            inst_valid <= 1'b0;
            arvalid    <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_master.sv
// Directed bench for ifu_fetch_master: cycle-exact checks from the main
// thread plus a negedge monitor scoring AR addresses and delivered instructions.
module tb_ifu_fetch_master;
  import ifu_pkg::*;

  logic              aclk;
  logic              aresetn;
  logic              arvalid;
  logic              arready;
  logic [PC_W-1:0]   araddr;
  logic              rvalid;
  logic              rready;
  logic [INST_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_err;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  logic [31:0] exp_ar_q[$];
  logic [63:0] exp_inst_q[$];

  ifu_fetch_master #(
    .RESET_PC(32'h8000_0000)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"},    64'(arvalid),    64'd0);
    check({tag, "_rready"},     64'(rready),     64'd0);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_inst"},       64'(inst),       64'd0);
    check({tag, "_inst_pc"},    64'(inst_pc),    64'd0);
    check({tag, "_inst_err"},   64'(inst_err),   64'd0);
    check({tag, "_araddr"},     64'(araddr),     64'h8000_0000);
    check({tag, "_state"},      64'(dbg_state),  64'(IDLE));
  endtask

  // ---------------- scoreboard monitor ----------------
  int          outstanding = 0;
  logic        ar_pending  = 1'b0;
  logic [31:0] ar_hold_addr = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      outstanding = 0;
      ar_pending  = 1'b0;
    end else begin
      if (ar_pending) begin
        check("ar_valid_held", 64'(arvalid), 64'd1);
        check("ar_addr_held",  64'(araddr),  64'(ar_hold_addr));
      end
      ar_pending   = arvalid && !arready;
      ar_hold_addr = araddr;
      if (arvalid && arready) begin
        check("one_outstanding", 64'(outstanding), 64'd0);
        if (exp_ar_q.size() == 0) begin
          check("ar_unexpected", 64'(araddr), 64'hffff_ffff_ffff_ffff);
        end else begin
          check("ar_addr_seq", 64'(araddr), 64'(exp_ar_q.pop_front()));
        end
        outstanding++;
      end
      if (rvalid && rready) outstanding--;
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_inst_q.size() == 0) begin
          check("inst_unexpected", {inst_pc, inst}, 64'hffff_ffff_ffff_ffff);
        end else begin
          check("inst_seq", {inst_pc, inst}, exp_inst_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    aresetn        = 1'b0;
    arready        = 1'b1;
    rvalid         = 1'b1;
    rdata          = 32'h0000_0413;
    rresp          = 2'b00;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    exp_ar_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000c,
                 32'h8000_0100, 32'h8000_0104, 32'h8000_0300, 32'h8000_0304,
                 32'h8000_0000, 32'h8000_0404, 32'h8000_0408};
    exp_inst_q = '{{32'h8000_0000, 32'h0000_0413}, {32'h8000_0004, 32'h0010_0093},
                   {32'h8000_0008, 32'h0020_0113}, {32'h8000_0100, 32'h0030_0193},
                   {32'h8000_0300, 32'h0040_0213}, {32'h8000_0404, 32'h0050_0293}};

    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("rst0");

    // Zero-wait fetch from RESET_PC
    aresetn = 1'b1;
    tick();
    check("c1_arvalid", 64'(arvalid), 64'd1);
    check("c1_araddr",  64'(araddr),  64'h8000_0000);
    tick();
    check("c2_rready",  64'(rready),  64'd1);
    check("c2_arvalid", 64'(arvalid), 64'd0);
    tick();
    check("c3_inst_valid", 64'(inst_valid), 64'd1);
    check("c3_inst",       64'(inst),       64'h0000_0413);
    check("c3_inst_pc",    64'(inst_pc),    64'h8000_0000);
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0010_0093;

    // Address wait states, then delayed read data
    for (int i = 0; i < 3; i++) begin
      tick();
      check("aw_arvalid",    64'(arvalid),    64'd1);
      check("aw_araddr",     64'(araddr),     64'h8000_0004);
      check("aw_inst_valid", 64'(inst_valid), 64'd0);
    end
    tick();
    arready = 1'b1;
    tick();
    check("dw_state",  64'(dbg_state), 64'(DATA));
    check("dw_rready", 64'(rready),    64'd1);
    tick();
    check("dw_inst_valid", 64'(inst_valid), 64'd0);
    tick();
    rvalid     = 1'b1;
    inst_ready = 1'b0;
    tick();
    check("dw_after_beat", 64'(inst_valid), 64'd1);

    // Decode stalls in HOLD for five cycles
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("hold_valid",   64'(inst_valid), 64'd1);
      check("hold_inst",    64'(inst),       64'h0010_0093);
      check("hold_pc",      64'(inst_pc),    64'h8000_0004);
      check("hold_arvalid", 64'(arvalid),    64'd0);
    end
    tick();
    inst_ready = 1'b1;
    rresp      = 2'b10;
    rdata      = 32'h0020_0113;
    tick();
    check("err_araddr", 64'(araddr), 64'h8000_0008);
    tick();
    tick();
    check("err_flag",    64'(inst_err), 64'd1);
    check("err_inst_pc", 64'(inst_pc),  64'h8000_0008);
    rresp = 2'b00;
    rdata = 32'hdead_beef;
    tick();
    check("err_no_stall", 64'(araddr), 64'h8000_000c);

    // Redirect in DATA on the same cycle as the beat
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    check("rd_araddr",     64'(araddr),     64'h8000_0100);
    check("rd_arvalid",    64'(arvalid),    64'd1);
    check("rd_inst_valid", 64'(inst_valid), 64'd0);
    rdata = 32'h0030_0193;
    tick();
    tick();
    check("rd_inst_pc",  64'(inst_pc),  64'h8000_0100);
    check("rd_inst_err", 64'(inst_err), 64'd0);
    arready = 1'b0;
    rdata   = 32'hbad0_0bad;

    // Two redirects while the address phase is stalled
    tick();
    check("ra_araddr0", 64'(araddr), 64'h8000_0104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    check("ra_araddr1", 64'(araddr), 64'h8000_0104);
    redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    arready        = 1'b1;
    tick();
    check("ra_state", 64'(dbg_state), 64'(DATA));
    tick();
    check("ra_araddr2",    64'(araddr),     64'h8000_0300);
    check("ra_inst_valid", 64'(inst_valid), 64'd0);
    rdata = 32'h0040_0213;
    tick();
    tick();
    check("ra_inst_pc", 64'(inst_pc), 64'h8000_0300);
    check("ra_inst",    64'(inst),    64'h0040_0213);
    rvalid = 1'b0;

    // Reset asserted mid-transaction
    tick();
    tick();
    check("mid_rready", 64'(rready), 64'd1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("rst1");
    tick();
    tick();
    rvalid  = 1'b1;
    rdata   = 32'h0000_0013;
    aresetn = 1'b1;
    tick();
    check("rr_araddr", 64'(araddr), 64'h8000_0000);
    tick();
    tick();
    check("rr_inst_pc", 64'(inst_pc), 64'h8000_0000);

    // Redirect in HOLD beats a simultaneous inst_ready
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0404;
    tick();
    redirect_valid = 1'b0;
    check("rh_inst_valid", 64'(inst_valid), 64'd0);
    check("rh_araddr",     64'(araddr),     64'h8000_0404);
    rdata = 32'h0050_0293;
    tick();
    tick();
    check("rh_inst_pc", 64'(inst_pc), 64'h8000_0404);
    tick();
    check("rh_next_araddr", 64'(araddr), 64'h8000_0408);
    inst_ready = 1'b0;
    repeat (3) tick();

    check("ar_q_drained",   64'(exp_ar_q.size()),   64'd0);
    check("inst_q_drained", 64'(exp_inst_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
